// File: rtl/mem_ctrl.sv
// Core-side request controller that turns byte/word reads and writes into
// byte accesses on a single-port RAM. Define MEM_ADDR_ERR_EN to add addr_err.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [14:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [14:0] mem_address,
  output logic [7:0]  mem_datain,
  input  logic [7:0]  mem_dataout,
  output logic        mem_we
`ifdef MEM_ADDR_ERR_EN
  ,
  output logic        addr_err
`endif
);

  // op[1] selects write, op[0] selects word
  localparam logic [1:0] OP_BYTE_RD = 2'b00;
  localparam logic [1:0] OP_WORD_RD = 2'b01;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [14:0] addr_q;
  logic [15:0] wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      addr_q   <= 15'd0;
      wdata_q  <= 16'd0;
      rsp_data <= 16'd0;
    end else begin
      state <= state_nxt;
      if (req_valid && req_ready) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      case (state)
        ACC0: begin
          if (op_q == OP_BYTE_RD)      rsp_data <= {8'h00, mem_dataout};
          else if (op_q == OP_WORD_RD) rsp_data[15:8] <= mem_dataout;
          else                         rsp_data <= 16'h0000;
        end
        ACC1: if (op_q == OP_WORD_RD) rsp_data[7:0] <= mem_dataout;
        default: ;
      endcase
    end
  end

  // RAM-side outputs are decoded from state so reset clears them without a clock
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_address = 15'd0;
    mem_datain  = 8'd0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACC0;
      end
      ACC0: begin
        mem_address = addr_q;
        if (op_q[1]) begin
          mem_we     = 1'b1;
          mem_datain = op_q[0] ? wdata_q[15:8] : wdata_q[7:0];
        end
        state_nxt = op_q[0] ? ACC1 : RESP;
      end
      ACC1: begin
        mem_address = addr_q + 15'd1;
        if (op_q[1]) begin
          mem_we     = 1'b1;
          mem_datain = wdata_q[7:0];
        end
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ADDR_ERR_EN
  assign addr_err = (state == RESP) && op_q[0] && (addr_q == 15'h7FFF);
`endif

endmodule
